// File: rtl/angle_pkg.sv
// Shared angle definitions for the steering ramp path: widths, direction encodings
// and the ramp controller state encoding.
package angle_pkg;

  localparam int unsigned ANGLE_W    = 12;
  localparam int unsigned ANGLE_FULL = 4096;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  typedef logic [ANGLE_W-1:0] angle_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_STEP     = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4
  } ramp_state_e;

endpackage

// File: rtl/angle_wrap_step.sv
// Combinational modular angle step: moves an angle by step counts in the given
// direction with wrap at one full revolution.
module angle_wrap_step
  import angle_pkg::*;
(
  input  logic [ANGLE_W-1:0] angle_i,
  input  logic [ANGLE_W-1:0] step_i,
  input  logic               dir_i,
  output logic [ANGLE_W-1:0] wrapped_c
);

  always_comb begin
    wrapped_c = angle_i;
    unique case (dir_i)
      DIR_CW:  wrapped_c = ANGLE_W'(angle_i + step_i);
      DIR_CCW: wrapped_c = ANGLE_W'(32'(angle_i) + ANGLE_FULL - 32'(step_i));
    endcase
  end

endmodule

// File: rtl/angle_ramp_gen.sv
// Issues a handshaked ramp of intermediate target angles from a start angle towards
// start +/- delta (mod 4096). Optional abort input enabled by defining RAMP_ABORT_EN.
module angle_ramp_gen
  import angle_pkg::*;
#(
  parameter int unsigned STEP_SIZE   = 64,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ANGLE_W-1:0] current_angle,
  input  logic [ANGLE_W-1:0] delta_angle,
  input  logic               dir,
  input  logic               target_ack,
`ifdef RAMP_ABORT_EN
  input  logic               abort,
`endif
  output logic [ANGLE_W-1:0] target_angle,
  output logic               target_valid,
  output logic               ramp_busy,
  output logic               ramp_done,
  output logic               ramp_error
);

  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [ANGLE_W-1:0] STEP_MAX = ANGLE_W'(STEP_SIZE);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  ramp_state_e        state_q, state_d;
  logic [ANGLE_W-1:0] target_q, target_d;
  logic [ANGLE_W-1:0] remain_q, remain_d;
  logic               dir_q, dir_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  logic [ANGLE_W-1:0] step_c;
  logic [ANGLE_W-1:0] next_angle_c;
  logic               abort_c;

`ifdef RAMP_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  assign step_c = (remain_q < STEP_MAX) ? remain_q : STEP_MAX;

  angle_wrap_step u_wrap (
    .angle_i   (target_q),
    .step_i    (step_c),
    .dir_i     (dir_q),
    .wrapped_c (next_angle_c)
  );

  // Next-state and registered-output logic; actions happen on the edge leaving a state.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    remain_d = remain_q;
    dir_d    = dir_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    error_d  = error_q;
    tmo_d    = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          target_d = current_angle;
          remain_d = delta_angle;
          dir_d    = dir;
          error_d  = 1'b0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = (remain_q == '0) ? ST_DONE : ST_STEP;
      end
      ST_STEP: begin
        target_d = next_angle_c;
        remain_d = remain_q - step_c;
        valid_d  = 1'b1;
        tmo_d    = '0;
        state_d  = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (target_ack) begin
          valid_d = 1'b0;
          state_d = (remain_q == '0) ? ST_DONE : ST_STEP;
        end else if (tmo_q == TMO_LAST) begin
          valid_d = 1'b0;
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over ack and timeout; target keeps the last issued value.
    if (abort_c && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      target_d = target_q;
      remain_d = remain_q;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      error_d  = error_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      remain_q <= '0;
      dir_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      remain_q <= remain_d;
      dir_q    <= dir_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      tmo_q    <= tmo_d;
    end
  end

  assign target_angle = target_q;
  assign target_valid = valid_q;
  assign ramp_busy    = busy_q;
  assign ramp_done    = done_q;
  assign ramp_error   = error_q;

endmodule

// File: tb/tb_angle_ramp_gen.sv
// Directed, table-driven bench for angle_ramp_gen: ramps, wrap, zero delta,
// ack timeout, mid-ramp reset and (with RAMP_ABORT_EN) abort.
module tb_angle_ramp_gen;
  import angle_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] current_angle = '0;
  logic [11:0] delta_angle = '0;
  logic        dir = 1'b0;
  logic        target_ack = 1'b0;
`ifdef RAMP_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic [11:0] target_angle;
  logic        target_valid;
  logic        ramp_busy;
  logic        ramp_done;
  logic        ramp_error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  angle_ramp_gen #(.STEP_SIZE(64), .TIMEOUT_CYC(1023)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .current_angle (current_angle),
    .delta_angle   (delta_angle),
    .dir           (dir),
    .target_ack    (target_ack),
`ifdef RAMP_ABORT_EN
    .abort         (abort),
`endif
    .target_angle  (target_angle),
    .target_valid  (target_valid),
    .ramp_busy     (ramp_busy),
    .ramp_done     (ramp_done),
    .ramp_error    (ramp_error)
  );

  typedef struct {
    logic [11:0] cur;
    logic [11:0] delta;
    logic        dir;
    int          ack_dly;
    bit          ack_lvl;
    logic [11:0] exp_final;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start a ramp, acknowledge each target after ack_dly cycles, check every target
  // against a running model and the end-of-ramp status.
  task automatic run_ramp(input vec_t v, input string tag);
    int          idx, first_evt, n_tgt, n_done, wcnt, rem, step;
    logic [11:0] model, held;
    bit          in_valid, finished;
    @(negedge clock);
    current_angle = v.cur;
    delta_angle   = v.delta;
    dir           = v.dir;
    start         = 1'b1;
    target_ack    = v.ack_lvl;
    @(negedge clock);
    start = 1'b0;
    model = v.cur; rem = int'(v.delta); held = '0;
    idx = 1; first_evt = 0; n_tgt = 0; n_done = 0; wcnt = 0;
    in_valid = 0; finished = 0;
    check({tag, " busy after start"}, 32'(ramp_busy), 32'd1);
    check({tag, " error cleared"}, 32'(ramp_error), 32'd0);
    for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
      if (target_valid) begin
        if (!in_valid) begin
          step = (rem < 64) ? rem : 64;
          model = v.dir ? 12'(int'(model) + step) : 12'(int'(model) - step);
          rem -= step;
          n_tgt++;
          if (first_evt == 0) first_evt = idx;
          check($sformatf("%s target%0d", tag, n_tgt), 32'(target_angle), 32'(model));
          held = target_angle;
          in_valid = 1;
          wcnt = 0;
        end else if (target_angle !== held) begin
          check({tag, " target stable"}, 32'(target_angle), 32'(held));
        end
        if (!v.ack_lvl) target_ack = (wcnt == v.ack_dly);
        wcnt++;
      end else begin
        in_valid = 0;
        if (!v.ack_lvl) target_ack = 1'b0;
      end
      if (ramp_done) begin
        n_done++;
        if (first_evt == 0) first_evt = idx;
      end
      if (!ramp_busy) finished = 1;
      else begin
        @(negedge clock);
        idx++;
      end
    end
    target_ack = 1'b0;
    check({tag, " finished in budget"}, 32'(finished), 32'd1);
    check({tag, " target count"}, 32'(n_tgt), 32'(v.exp_cnt));
    check({tag, " final angle"}, 32'(target_angle), 32'(v.exp_final));
    check({tag, " done pulses"}, 32'(n_done), 32'd1);
    check({tag, " first event cycle"}, 32'(first_evt), 32'd3);
    check({tag, " valid low at end"}, 32'(target_valid), 32'd0);
    check({tag, " error low at end"}, 32'(ramp_error), 32'd0);
  endtask

  initial begin
    int cnt, n;
    bit inv;
    vecs[0] = '{12'd100,  12'd924,  1'b1, 2, 1'b0, 12'd1024, 15};
    vecs[1] = '{12'd1024, 12'd924,  1'b0, 2, 1'b0, 12'd100,  15};
    vecs[2] = '{12'd3600, 12'd696,  1'b1, 1, 1'b0, 12'd200,  11};
    vecs[3] = '{12'd777,  12'd0,    1'b1, 0, 1'b0, 12'd777,  0};
    vecs[4] = '{12'd0,    12'd4095, 1'b0, 0, 1'b1, 12'd1,    64};
    vecs[5] = '{12'd4000, 12'd2049, 1'b1, 3, 1'b0, 12'd1953, 33};

    repeat (2) @(negedge clock);
    check("reset target", 32'(target_angle), 32'd0);
    check("reset valid", 32'(target_valid), 32'd0);
    check("reset busy", 32'(ramp_busy), 32'd0);
    check("reset done", 32'(ramp_done), 32'd0);
    check("reset error", 32'(ramp_error), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) run_ramp(vecs[i], $sformatf("vec%0d", i));

    // Ack withheld: target held for TIMEOUT_CYC cycles, then sticky error.
    @(negedge clock);
    current_angle = 12'd500; delta_angle = 12'd100; dir = DIR_CW; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cnt = 0;
    while (!target_valid && cnt < 10) begin
      @(negedge clock);
      cnt++;
    end
    check("timeout valid seen", 32'(target_valid), 32'd1);
    cnt = 0;
    while (target_valid && cnt < 2000) begin
      if (ramp_done) check("timeout no done", 32'(ramp_done), 32'd0);
      cnt++;
      @(negedge clock);
    end
    check("timeout cycles", 32'(cnt), 32'd1023);
    check("timeout error", 32'(ramp_error), 32'd1);
    check("timeout busy", 32'(ramp_busy), 32'd0);
    check("timeout done", 32'(ramp_done), 32'd0);
    check("timeout target", 32'(target_angle), 32'd564);
    run_ramp(vecs[3], "after_timeout");

    // Asynchronous reset while the third target is outstanding.
    @(negedge clock);
    current_angle = 12'd100; delta_angle = 12'd924; dir = DIR_CW; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0; inv = 0;
    for (int cyc = 0; cyc < 200 && n < 3; cyc++) begin
      @(negedge clock);
      if (target_valid && !inv) begin
        n++;
        inv = 1;
        target_ack = (n < 3);
      end else begin
        if (!target_valid) inv = 0;
        target_ack = 1'b0;
      end
    end
    target_ack = 1'b0;
    check("pre-reset third target", 32'(target_angle), 32'd292);
    #2 reset_n = 1'b0;
    #1;
    check("midreset target", 32'(target_angle), 32'd0);
    check("midreset valid", 32'(target_valid), 32'd0);
    check("midreset busy", 32'(ramp_busy), 32'd0);
    check("midreset done", 32'(ramp_done), 32'd0);
    check("midreset error", 32'(ramp_error), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_ramp(vecs[0], "after_reset");

`ifdef RAMP_ABORT_EN
    // Abort while the second target is outstanding.
    @(negedge clock);
    current_angle = 12'd2000; delta_angle = 12'd500; dir = DIR_CCW; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0; inv = 0;
    for (int cyc = 0; cyc < 200 && n < 2; cyc++) begin
      @(negedge clock);
      if (target_valid && !inv) begin
        n++;
        inv = 1;
        target_ack = (n < 2);
      end else begin
        if (!target_valid) inv = 0;
        target_ack = 1'b0;
      end
    end
    check("abort second target", 32'(target_angle), 32'd1872);
    abort = 1'b1;
    target_ack = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    target_ack = 1'b0;
    check("abort busy", 32'(ramp_busy), 32'd0);
    check("abort valid", 32'(target_valid), 32'd0);
    check("abort done", 32'(ramp_done), 32'd0);
    check("abort target held", 32'(target_angle), 32'd1872);
    cnt = 0;
    repeat (4) begin
      @(negedge clock);
      if (ramp_done || ramp_busy) cnt++;
    end
    check("abort stays idle", 32'(cnt), 32'd0);
    run_ramp(vecs[2], "after_abort");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
